// File: rtl/detect_event_logger.sv
// detect_event_logger: timestamps detection pulses, counts them, and buffers the stamps in a FWFT FIFO
// Ports:
//   clk, rst (async active-low)
//   detected   - detection pulse, pushes the current timestamp
//   clear      - synchronous flush of FIFO, counters and flags
//   evt_valid / evt_ready / evt_ts - FIFO head handshake
//   evt_count  - saturating detection count, including drops
//   fifo_level - occupancy
//   overflow   - sticky drop flag
//   evt_gap    - head entry gap, present only with DETLOG_GAP_EN defined
module detect_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     detected,
    input  logic                     clear,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [CNT_W-1:0]         evt_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
`ifdef DETLOG_GAP_EN
    ,
    output logic [TS_W-1:0]          evt_gap
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [TS_W-1:0]  mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             pop, push;

    always_comb begin
        pop   = (lvl_q != '0) && evt_ready;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push  = detected && ((lvl_q != (AW+1)'(DEPTH)) || pop);
        ts_d  = clear ? '0 : ts_q + TS_W'(1);
        wp_d  = clear ? '0 : wp_q + AW'(push);
        rp_d  = clear ? '0 : rp_q + AW'(pop);
        lvl_d = clear ? '0 : lvl_q + (AW+1)'(push) - (AW+1)'(pop);
        cnt_d = clear ? '0 : cnt_q + CNT_W'(detected && (cnt_q != '1));
        ovf_d = !clear && (ovf_q || (detected && !push));
        mem_d = mem_q;
        if (push) mem_d[wp_q] = ts_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q  <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ts_q  <= ts_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            mem_q <= mem_d;
        end
    end

    assign evt_valid  = lvl_q != '0;
    assign evt_ts     = mem_q[rp_q];
    assign evt_count  = cnt_q;
    assign fifo_level = lvl_q;
    assign overflow   = ovf_q;

`ifdef DETLOG_GAP_EN
    logic [TS_W-1:0] gap_q [DEPTH];
    logic [TS_W-1:0] gap_d [DEPTH];
    logic [TS_W-1:0] gcnt_q, gcnt_d;
    logic            first_q, first_d;

    // gcnt counts cycles since the last stored event; dropped events leave it alone
    always_comb begin
        gcnt_d  = clear ? '0 : push ? TS_W'(1) : gcnt_q + TS_W'(gcnt_q != '1);
        first_d = clear || (first_q && !push);
        gap_d   = gap_q;
        if (push) gap_d[wp_q] = first_q ? '0 : gcnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcnt_q  <= '0;
            first_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) gap_q[i] <= '0;
        end else begin
            gcnt_q  <= gcnt_d;
            first_q <= first_d;
            gap_q   <= gap_d;
        end
    end

    assign evt_gap = gap_q[rp_q];
`endif
endmodule

// File: doc/detect_event_logger.md
# detect_event_logger

Downstream consumer of the serial pattern detector's one-cycle `detected` pulse. Stamps every detection with a free-running cycle timestamp, counts detections, and buffers the stamps in a small first-word-fall-through FIFO. The FIFO drains over a valid/ready handshake toward the host or readout logic. Overflow is reported as a sticky flag and never stalls the detector.

## Interface
- `TS_W`, 16, width of the timestamp counter and of each FIFO entry
- `DEPTH`, 4, FIFO entries; must be a power of two, at least 2
- `CNT_W`, 8, width of the saturating detection counter
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0)
- `detected`  in  1  detection pulse from the pattern detector, sampled each rising edge
- `clear`  in  1  synchronous flush: empties the FIFO and zeroes the counters and flags
- `evt_valid`  out  1  FIFO not empty
- `evt_ready`  in  1  consumer accepts the head entry
- `evt_ts`  out  TS_W  timestamp at the FIFO head
- `evt_count`  out  CNT_W  total detections seen, including dropped ones; saturating
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky; at least one detection was dropped

## Operation
- Timestamp register `ts`:
  - increments by 1 every cycle
  - wraps from 2^TS_W-1 to 0
- Push: `detected`=1 at an edge writes the current `ts` value (the pre-increment value) to the tail.
- Pop: `evt_valid`=1 and `evt_ready`=1 at an edge removes the head.
- `evt_ts` always shows the head entry. Its value is don't-care when `evt_valid`=0.
- Full and push without pop:
  - the entry is dropped
  - `overflow` is set to 1
  - `evt_count` still increments
- Full and push with pop in the same cycle: both are performed and the level stays at DEPTH. No drop occurs.
- Empty and push with pop in the same cycle: there is no pop, because `evt_valid`=0. The push is performed.
- `evt_count`:
  - increments on every `detected`=1
  - saturates at 2^CNT_W-1 and does not wrap
- `overflow` is cleared only by `rst` or `clear`.
- `clear`=1 at an edge:
  - `ts`, `evt_count`, `overflow` and `fifo_level` go to 0 and the FIFO empties
  - `clear` dominates a concurrent `detected` (the event is neither counted nor stored) and a concurrent pop
- Back-to-back `detected` pulses on consecutive cycles are each accepted.

## Timing
- Reset values: `evt_valid`=0, `evt_ts`=0, `evt_count`=0, `fifo_level`=0, `overflow`=0. The internal `ts` is 0.
- Reset is taken mid-operation with no handshake; all buffered entries are lost.
- Latency from a `detected` edge to `evt_valid`=1 on an empty FIFO is 1 cycle. `evt_ts` is valid in the same cycle.
- `evt_ts` and `evt_valid` are registered and combinational-free with respect to `evt_ready`.
- Throughput is one push and one pop per cycle.
- `fifo_level` and `evt_count` update one cycle after the causing edge.

## Configuration
- Macro `DETLOG_GAP_EN`.
- Defined:
  - each FIFO entry additionally stores a TS_W-bit gap: cycles since the previous accepted (stored) event, saturating at 2^TS_W-1
  - a new output `evt_gap`, out, TS_W bits, presents the head entry's gap
  - the first event after reset or `clear` stores a gap of 0
  - dropped events do not update the gap reference
- Not defined: the `evt_gap` port and gap storage are absent. All other behaviour is identical.

## Test plan
- Reset then `detected` pulses at `ts`=5 and `ts`=9, with `evt_ready`=1 -> `evt_valid` high for 1 cycle each, `evt_ts`=5 then 9, `evt_count`=2, `overflow`=0.
- `evt_ready`=0, 5 pulses with DEPTH=4 -> `fifo_level`=4, `overflow`=1, `evt_count`=5. Draining then yields the first four timestamps in order, after which `evt_valid`=0.
- FIFO full, `detected`=1 and `evt_ready`=1 in the same cycle -> `fifo_level` stays 4, `overflow` stays 0, the new timestamp lands at the tail.
- Pulse with CNT_W=8 after 255 prior detections -> `evt_count` holds 255. Run `ts` past 65535 -> the next stamp wraps to a small value.
- `clear`=1 coincident with `detected`=1 and 3 entries buffered -> next cycle `fifo_level`=0, `evt_count`=0, `overflow`=0, `evt_valid`=0. Then `rst`=0 mid-drain -> all outputs are at reset values immediately.
- With `DETLOG_GAP_EN`: pulses at `ts`=2, 7, 8 -> `evt_gap` values 0, 5, 1.
